// File: rtl/cpu_pkg.sv
// Shared opcode, state and phase definitions for the 4-bit CPU phase sequencer.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_OUT  = 4'b0011;
  localparam logic [3:0] OP_IN   = 4'b0100;
  localparam logic [3:0] OP_LOAD = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [3:0] PH_NONE = 4'b0000;
  localparam logic [3:0] PH0     = 4'b0001;
  localparam logic [3:0] PH1     = 4'b0010;
  localparam logic [3:0] PH2     = 4'b0100;
  localparam logic [3:0] PH3     = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4,
    ST_HALT = 3'd5
  } seq_state_e;

  // Opcodes 0110..1110 are undefined and run as NOP.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_LOAD) || (op == OP_HALT);
  endfunction

  function automatic logic [3:0] phase_of(input seq_state_e st);
    case (st)
      ST_P0:   return PH0;
      ST_P1:   return PH1;
      ST_P2:   return PH2;
      ST_P3:   return PH3;
      default: return PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cpu_phase_sequencer_wait_timer.sv
// Counts stalled memory-phase cycles; expired_o flags that WAIT_LIMIT stalls have elapsed.
module wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int TW = $clog2(WAIT_LIMIT + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == TW'(WAIT_LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_phase_sequencer.sv
// One-hot fetch/decode/execute phase ring with run/step control, memory stall and halt handling.
module cpu_phase_sequencer
  import cpu_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 8
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             Run,
  input  logic             Step,
  input  logic             MemReady,
  input  logic [3:0]       Instr,
  output logic [3:0]       Phase,
  output logic             Busy,
  output logic             Halted,
  output logic             BusError,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InstrCount
);

  seq_state_e       state_q, state_d;
  logic [3:0]       phase_q;
  logic             busy_q, halted_q, buserr_q, illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_wait, timer_clr, timer_expired, bus_err_set;

  // A phase is stalling when it reads memory and the bus has not answered yet.
  assign mem_wait  = !MemReady &&
                     ((state_q == ST_P0) || ((state_q == ST_P2) && (Instr == OP_LOAD)));
  assign timer_clr = (state_d != state_q);

  wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk_i     (Clk),
    .rst_ni    (ResetN),
    .clr_i     (timer_clr),
    .en_i      (mem_wait),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    bus_err_set = 1'b0;
    case (state_q)
      ST_IDLE: if (Run || Step) state_d = ST_P0;
      ST_P0: begin
        if (MemReady) begin
          state_d = ST_P1;
        end else if (timer_expired) begin
          state_d     = ST_HALT;
          bus_err_set = 1'b1;
        end
      end
      ST_P1:   state_d = (Instr == OP_HALT) ? ST_HALT : ST_P2;
      ST_P2: begin
        if (!mem_wait) begin
          state_d = ST_P3;
        end else if (timer_expired) begin
          state_d     = ST_HALT;
          bus_err_set = 1'b1;
        end
      end
      ST_P3:   state_d = Run ? ST_P0 : ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  assign illegal_d = (state_q == ST_P1) && (state_d == ST_P2) && !op_is_legal(Instr);
  assign cnt_d     = (state_q == ST_P3) ? cnt_q + CNT_W'(1) : cnt_q;

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_NONE;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      buserr_q  <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_of(state_d);
      busy_q    <= (phase_of(state_d) != PH_NONE);
      halted_q  <= (state_d == ST_HALT);
      buserr_q  <= buserr_q | bus_err_set;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign Phase      = phase_q;
  assign Busy       = busy_q;
  assign Halted     = halted_q;
  assign BusError   = buserr_q;
  assign IllegalOp  = illegal_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Scoreboard bench for cpu_phase_sequencer: expected phases are queued per driven cycle.
module tb_cpu_phase_sequencer;

  logic       Clk = 1'b0;
  logic       ResetN = 1'b0;
  logic       Run = 1'b0;
  logic       Step = 1'b0;
  logic       MemReady = 1'b1;
  logic [3:0] Instr = 4'b0000;
  logic [3:0] Phase;
  logic       Busy, Halted, BusError, IllegalOp;
  logic [7:0] InstrCount;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  cpu_phase_sequencer #(.WAIT_LIMIT(15), .CNT_W(8)) dut (
    .Clk(Clk), .ResetN(ResetN), .Run(Run), .Step(Step), .MemReady(MemReady),
    .Instr(Instr), .Phase(Phase), .Busy(Busy), .Halted(Halted),
    .BusError(BusError), .IllegalOp(IllegalOp), .InstrCount(InstrCount)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the phase expected after the next edge, then compare.
  task automatic cyc(input logic run, input logic step, input logic mr, input logic [3:0] exp_ph);
    logic [3:0] e;
    Run = run; Step = step; MemReady = mr;
    exp_q.push_back(exp_ph);
    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check_val("phase", {28'd0, Phase}, {28'd0, e});
      check_val("busy", {31'd0, Busy}, {31'd0, (e != 4'b0000)});
    end
  endtask

  task automatic do_reset();
    Run = 0; Step = 0; MemReady = 1;
    ResetN = 0;
    repeat (2) @(posedge Clk);
    #1;
    ResetN = 1;
    check_val("rst_phase", {28'd0, Phase}, 0);
    check_val("rst_flags", {28'd0, Busy, Halted, BusError, IllegalOp}, 0);
    check_val("rst_count", {24'd0, InstrCount}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Free-run, 10 instructions back to back, then Run dropped mid-instruction.
    do_reset();
    Instr = 4'b0001;
    for (int i = 0; i < 41; i++) cyc(1, 0, 1, 4'(1 << (i % 4)));
    check_val("free_run_count10", {24'd0, InstrCount}, 10);
    cyc(0, 0, 1, 4'b0010);
    cyc(0, 0, 1, 4'b0100);
    cyc(0, 0, 1, 4'b1000);
    cyc(0, 0, 1, 4'b0000);
    check_val("run_drop_count", {24'd0, InstrCount}, 11);

    // Single step; a second Step during P2 is ignored.
    do_reset();
    Instr = 4'b0011;
    cyc(0, 1, 1, 4'b0001);
    cyc(0, 0, 1, 4'b0010);
    cyc(0, 0, 1, 4'b0100);
    cyc(0, 1, 1, 4'b1000);
    cyc(0, 0, 1, 4'b0000);
    cyc(0, 0, 1, 4'b0000);
    check_val("step_count", {24'd0, InstrCount}, 1);

    // LOAD with stalls: 3 in fetch, 2 in execute -> 9-cycle instruction.
    do_reset();
    Instr = 4'b0101;
    cyc(0, 1, 0, 4'b0001);
    cyc(0, 0, 0, 4'b0001);
    cyc(0, 0, 0, 4'b0001);
    cyc(0, 0, 0, 4'b0001);
    cyc(0, 0, 1, 4'b0010);
    cyc(0, 0, 1, 4'b0100);
    cyc(0, 0, 0, 4'b0100);
    cyc(0, 0, 0, 4'b0100);
    cyc(0, 0, 1, 4'b1000);
    cyc(0, 0, 1, 4'b0000);
    check_val("load_count", {24'd0, InstrCount}, 1);
    check_val("load_no_buserr", {31'd0, BusError}, 0);

    // Memory timeout: fetch lasts WAIT_LIMIT+1 = 16 cycles, then bus-error halt.
    do_reset();
    Instr = 4'b0001;
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 4'b0001);
    cyc(1, 0, 0, 4'b0000);
    check_val("timeout_halted", {31'd0, Halted}, 1);
    check_val("timeout_buserr", {31'd0, BusError}, 1);
    for (int i = 0; i < 6; i++) cyc(i[0], i[1], 1, 4'b0000);
    check_val("halt_sticky", {30'd0, Halted, BusError}, 3);
    check_val("timeout_count", {24'd0, InstrCount}, 0);

    // HALT opcode in free-run.
    do_reset();
    Instr = 4'b1111;
    cyc(1, 0, 1, 4'b0001);
    cyc(1, 0, 1, 4'b0010);
    cyc(1, 0, 1, 4'b0000);
    check_val("halt_op_halted", {31'd0, Halted}, 1);
    check_val("halt_op_buserr", {31'd0, BusError}, 0);
    cyc(1, 0, 1, 4'b0000);
    check_val("halt_op_count", {24'd0, InstrCount}, 0);

    // Illegal opcode: IllegalOp only in first P2 cycle, still counted.
    do_reset();
    Instr = 4'b0111;
    cyc(0, 1, 1, 4'b0001);
    check_val("illegal_p0", {31'd0, IllegalOp}, 0);
    cyc(0, 0, 1, 4'b0010);
    check_val("illegal_p1", {31'd0, IllegalOp}, 0);
    cyc(0, 0, 1, 4'b0100);
    check_val("illegal_p2", {31'd0, IllegalOp}, 1);
    cyc(0, 0, 1, 4'b1000);
    check_val("illegal_p3", {31'd0, IllegalOp}, 0);
    cyc(0, 0, 1, 4'b0000);
    check_val("illegal_count", {24'd0, InstrCount}, 1);

    // Asynchronous reset during P2, then restart.
    do_reset();
    Instr = 4'b0001;
    cyc(1, 0, 1, 4'b0001);
    cyc(1, 0, 1, 4'b0010);
    cyc(1, 0, 1, 4'b0100);
    #1;
    ResetN = 0;
    #1;
    check_val("async_rst_phase", {28'd0, Phase}, 0);
    check_val("async_rst_busy", {31'd0, Busy}, 0);
    @(negedge Clk);
    ResetN = 1;
    @(posedge Clk);
    #1;
    check_val("post_rst_phase", {28'd0, Phase}, 4'b0001);

    // Counter wrap: 256 instructions bring InstrCount back to 0.
    do_reset();
    for (int i = 0; i < 1021; i++) cyc(1, 0, 1, 4'(1 << (i % 4)));
    check_val("count_255", {24'd0, InstrCount}, 255);
    for (int i = 1021; i < 1025; i++) cyc(1, 0, 1, 4'(1 << (i % 4)));
    check_val("count_wrap", {24'd0, InstrCount}, 0);

    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_phase_sequencer.md
# cpu_phase_sequencer

Generates the one-hot Phase[3:0] ring that drives the microinstruction decoder of the 4-bit CPU, sequencing each instruction through fetch (Phase0), decode (Phase1) and execute (Phase2, Phase3). It supports free-run and single-step modes. It stalls memory-reading phases on a ready handshake and halts on the HALT opcode or a memory timeout. It sits between the front-panel/testbench control inputs and the decoder; the decoder's outputs are unchanged.

## Interface
- WAIT_LIMIT, 15: max stalled cycles allowed in a memory phase before bus-error halt (1..255)
- CNT_W, 8: width of retired-instruction counter
- Clk  in  1  system clock, rising edge
- ResetN  in  1  reset, asynchronous, active-low
- Run  in  1  level; 1 = free-run instructions back to back
- Step  in  1  one-cycle pulse; starts exactly one instruction when idle and Run=0
- MemReady  in  1  memory ready handshake for ReadMem phases
- Instr  in  4  opcode from instruction register; valid from first Phase1 cycle
- Phase  out  4  one-hot phase to decoder, bit n = Phasen; 0000 when idle/halted
- Busy  out  1  1 while an instruction is in progress (Phase != 0000)
- Halted  out  1  sticky; set on HALT opcode or bus error
- BusError  out  1  sticky; set on MemReady timeout
- IllegalOp  out  1  one-cycle pulse on undefined opcode
- InstrCount  out  CNT_W  retired instructions, wraps

## Operation
- Opcodes: NOP 0000, ADD 0001, SUB 0010, OUT 0011, IN 0100, LOAD 0101, HALT 1111. Opcodes 0110-1110 are illegal; they execute as NOP and pulse IllegalOp.
- States: IDLE, P0, P1, P2, P3, HALT. Phase is the one-hot of P0..P3, 0000 in IDLE/HALT.
- IDLE → P0 if Run=1 or Step=1. Step in any other state is ignored, not queued.
- P0 (fetch, memory read): wait while MemReady=0. → P1 on a cycle with MemReady=1.
- P1 → HALT if Instr=1111. Otherwise → P2.
- P2: if Instr=LOAD (memory read), wait on MemReady as in P0. Otherwise → P3 unconditionally.
- P3 → P0 if Run=1, else → IDLE. InstrCount increments on leaving P3.
- HALT is left only by reset. Run and Step are ignored.
- Wait timer: clears on entry to any state. It increments each cycle a memory phase sees MemReady=0. If timer=WAIT_LIMIT and MemReady=0 → HALT with BusError=1.
- Run dropped mid-instruction: the current instruction completes through P3, then → IDLE.
- HALT does not increment InstrCount. Illegal opcodes do increment it.

## Timing
- All outputs are registered. Reset values: Phase=0000, Busy=0, Halted=0, BusError=0, IllegalOp=0, InstrCount=0. Wait timer=0, state=IDLE.
- Reset asserted mid-instruction: outputs return to reset values immediately (asynchronous), with no completion.
- Run/Step sampled high in IDLE at edge k → Phase=0001 after edge k.
- With MemReady=1 always, each instruction is exactly 4 cycles. In free-run the sequence is 0001,0010,0100,1000,0001… with no gap.
- Each MemReady=0 cycle in P0, or in P2 for LOAD, extends that phase by one cycle.
- Timeout: a memory phase lasts at most WAIT_LIMIT+1 cycles. On the next edge: Phase=0000, Halted=1, BusError=1.
- IllegalOp is high during the first Phase2 cycle of the illegal instruction only.
- Halted rises on the edge after the last Phase1 cycle of HALT; Phase=0000 on the same edge.
- InstrCount updates on the edge that leaves P3. Wrap is 2^CNT_W-1 → 0.

## Structure
- Shared package cpu_pkg:
  - opcode constants OP_NOP..OP_LOAD, OP_HALT
  - sequencer state enum
  - one-hot phase constants PH0..PH3
- Sub-module wait_timer:
  - parameterised by WAIT_LIMIT
  - inputs: clear, count-enable
  - output: expired flag
- The FSM, instruction counter and output registers stay in cpu_phase_sequencer.

## Test plan
- Reset, Run=1, MemReady=1, Instr=0001 → Phase cycles 0001,0010,0100,1000 repeating. After 10 instructions, InstrCount=10 and Busy stays 1.
- Run=0, Step pulse, Instr=0011 → one 4-cycle pass, then Phase=0000 and InstrCount=1. A second Step pulse during P2 has no effect.
- Instr=0101, MemReady low 3 cycles in P0 and 2 cycles in P2 → Phase0 lasts 4 cycles, Phase2 lasts 3, instruction takes 9 cycles.
- MemReady held 0, WAIT_LIMIT=15 → Phase0 lasts 16 cycles, then Phase=0000, Halted=1, BusError=1. Run toggling afterward changes nothing.
- Instr=1111 in free-run → Phase 0001,0010 then 0000 with Halted=1, BusError=0, InstrCount unchanged. Instr=0111 → IllegalOp pulse with first Phase2 and InstrCount+1.
- ResetN low during Phase2 → all outputs zero immediately. After release with Run=1, first Phase=0001. With CNT_W=8, 256 instructions wrap InstrCount to 0.
